// File: rtl/mult_pkg.sv
// Shared widths and helpers for the sign-magnitude multiplier.
//   res_w(a,b) : product width including sign bit
//   mag_w(a,b) : product magnitude width
//   sign_pos(w): bit index of the sign in a w-bit sign-magnitude word
package mult_pkg;

    // Default operand widths (sign bit included).
    localparam int unsigned DEF_DATAA_W = 5;
    localparam int unsigned DEF_DATAB_W = 10;

    // Sign-bit positions of the default operands and product.
    localparam int unsigned DEF_SIGN_A   = DEF_DATAA_W - 1;
    localparam int unsigned DEF_SIGN_B   = DEF_DATAB_W - 1;
    localparam int unsigned DEF_SIGN_RES = DEF_DATAA_W + DEF_DATAB_W - 2;

    function automatic int unsigned res_w(input int unsigned a, input int unsigned b);
        return a + b - 1;
    endfunction

    function automatic int unsigned mag_w(input int unsigned a, input int unsigned b);
        return a + b - 2;
    endfunction

    function automatic int unsigned sign_pos(input int unsigned w);
        return w - 1;
    endfunction

endpackage

// File: rtl/mult_mag.sv
// Unsigned combinational magnitude multiplier built as a shift-add
// partial-product array, so it maps onto plain fabric.
// Ports:
//   mag_a  in  A_W          : unsigned multiplicand
//   mag_b  in  B_W          : unsigned multiplier
//   prod_c out A_W+B_W      : full, untruncated product
module mult_mag #(
    parameter int unsigned A_W = 4,
    parameter int unsigned B_W = 9
) (
    input  logic [A_W-1:0]     mag_a,
    input  logic [B_W-1:0]     mag_b,
    output logic [A_W+B_W-1:0] prod_c
);

    localparam int unsigned P_W = A_W + B_W;

    logic [P_W-1:0] b_ext;
    logic [P_W-1:0] acc;

    assign b_ext = P_W'(mag_b);

    // Accumulate one shifted copy of B per set bit of A.
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < A_W; i++) begin
            if (mag_a[i]) begin
                acc = acc + (b_ext << i);
            end
        end
    end

    assign prod_c = acc;

endmodule

// File: rtl/mult.sv
// Registered sign-magnitude multiplier.
// Ports:
//   iClk    in  1                 : clock, rising edge
//   iRst    in  1                 : synchronous active-high reset (priority over iEn)
//   iEn     in  1                 : capture a new product at this edge
//   iDataa  in  demention_dataa   : operand A, MSB sign, rest magnitude
//   iDatab  in  demention_datab   : operand B, same format
//   oResult out dataa+datab-1     : registered sign-magnitude product
//   oValid  out 1                 : high the cycle after an enabled edge
module mult
    import mult_pkg::*;
#(
    parameter int unsigned demention_dataa = DEF_DATAA_W,
    parameter int unsigned demention_datab = DEF_DATAB_W
) (
    input  logic                                         iClk,
    input  logic                                         iRst,
    input  logic                                         iEn,
    input  logic [demention_dataa-1:0]                   iDataa,
    input  logic [demention_datab-1:0]                   iDatab,
    output logic [demention_dataa+demention_datab-2:0]   oResult,
    output logic                                         oValid
);

    localparam int unsigned RES_W  = res_w(demention_dataa, demention_datab);
    localparam int unsigned MAG_W  = mag_w(demention_dataa, demention_datab);
    localparam int unsigned SIGN_A = sign_pos(demention_dataa);
    localparam int unsigned SIGN_B = sign_pos(demention_datab);

    logic [MAG_W-1:0] mag_c;
    logic             sign_c;
    logic [RES_W-1:0] result_d, result_q;
    logic             valid_d, valid_q;

    // Unsigned magnitude product.
    mult_mag #(
        .A_W(demention_dataa - 1),
        .B_W(demention_datab - 1)
    ) u_mag (
        .mag_a (iDataa[SIGN_A-1:0]),
        .mag_b (iDatab[SIGN_B-1:0]),
        .prod_c(mag_c)
    );

    // Sign is the XOR of operand signs, forced positive for a zero product.
    assign sign_c = (iDataa[SIGN_A] ^ iDatab[SIGN_B]) & (|mag_c);

    // Next-state: capture on enable, otherwise hold result and drop valid.
    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        if (iEn) begin
            result_d = {sign_c, mag_c};
            valid_d  = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign oResult = result_q;
    assign oValid  = valid_q;

endmodule

// File: tb/tb_mult.sv
// Directed and random checks of mult at default widths (5 x 10 -> 14).
module tb_mult;

    logic        iClk;
    logic        iRst;
    logic        iEn;
    logic [4:0]  iDataa;
    logic [9:0]  iDatab;
    logic [13:0] oResult;
    logic        oValid;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [13:0] exp_res_q[$];
    logic        exp_val_q[$];
    logic [13:0] m_res = '0;
    logic        m_val = 1'b0;

    mult #(
        .demention_dataa(5),
        .demention_datab(10)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iDataa (iDataa),
        .iDatab (iDatab),
        .oResult(oResult),
        .oValid (oValid)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference sign-magnitude product.
    function automatic logic [13:0] ref_prod(input logic [4:0] a, input logic [9:0] b);
        int unsigned m;
        logic        s;
        m = int'(a[3:0]) * int'(b[8:0]);
        s = (a[4] ^ b[9]) && (m != 0);
        return {s, 13'(m)};
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle at the falling edge, predict, then check after the rising edge.
    task automatic step(input logic [4:0] a, input logic [9:0] b,
                        input logic en, input logic rst, input string tag);
        logic [13:0] er;
        logic        ev;
        iDataa = a;
        iDatab = b;
        iEn    = en;
        iRst   = rst;
        if (rst) begin
            m_res = '0;
            m_val = 1'b0;
        end else if (en) begin
            m_res = ref_prod(a, b);
            m_val = 1'b1;
        end else begin
            m_val = 1'b0;
        end
        exp_res_q.push_back(m_res);
        exp_val_q.push_back(m_val);
        @(posedge iClk);
        @(negedge iClk);
        if (exp_res_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            er = exp_res_q.pop_front();
            ev = exp_val_q.pop_front();
            chk({tag, "_res"}, oResult, er);
            chk({tag, "_val"}, {13'b0, oValid}, {13'b0, ev});
        end
    endtask

    initial begin
        logic [13:0] held;
        iRst   = 1'b1;
        iEn    = 1'b0;
        iDataa = '0;
        iDatab = '0;
        @(negedge iClk);

        // Reset state.
        step(5'b00101, 10'b0000000011, 1'b1, 1'b1, "reset");
        chk("reset_const", oResult, 14'h0000);

        // Directed products with spelled-out expectations.
        step(5'b01000, 10'b1000001001, 1'b1, 1'b0, "p8xm9");
        chk("p8xm9_const", oResult, 14'h2048);
        chk("p8xm9_valid", {13'b0, oValid}, 14'h0001);
        step(5'b11010, 10'b1000001101, 1'b1, 1'b0, "m10xm13");
        chk("m10xm13_const", oResult, 14'h0082);
        step(5'b01111, 10'b0000000000, 1'b1, 1'b0, "p15x0");
        chk("p15x0_const", oResult, 14'h0000);
        step(5'b11111, 10'b0000000000, 1'b1, 1'b0, "m15xp0");
        chk("m15xp0_const", oResult, 14'h0000);
        step(5'b10000, 10'b1000000101, 1'b1, 1'b0, "m0xm5");
        chk("m0xm5_const", oResult, 14'h0000);
        step(5'b01111, 10'b0111111111, 1'b1, 1'b0, "maxpos");
        chk("maxpos_const", oResult, 14'h1DF1);
        step(5'b11111, 10'b0111111111, 1'b1, 1'b0, "maxneg");
        chk("maxneg_const", oResult, 14'h3DF1);
        chk("maxneg_valid", {13'b0, oValid}, 14'h0001);

        // Hold: capture, then three disabled cycles with changing inputs.
        step(5'b01000, 10'b1000001001, 1'b1, 1'b0, "cap");
        held = 14'h2048;
        for (int i = 0; i < 3; i++) begin
            step(5'(i + 3), 10'(i * 77 + 5), 1'b0, 1'b0, "hold");
            chk("hold_const", oResult, held);
            chk("hold_valid", {13'b0, oValid}, 14'h0000);
        end

        // Reset wins over enable and discards the product at that edge.
        step(5'b00111, 10'b0000000111, 1'b1, 1'b0, "pre_rst");
        step(5'b01111, 10'b0111111111, 1'b1, 1'b1, "rst_en");
        chk("rst_en_const", oResult, 14'h0000);
        chk("rst_en_valid", {13'b0, oValid}, 14'h0000);

        // Random sweep against the reference model.
        for (int i = 0; i < 1000; i++) begin
            step(5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
